// File: rtl/rd_ptr_ctrl.sv
// rd_ptr_ctrl: read-side pointer controller for an asynchronous FIFO.
// Lives entirely in the read clock domain. The Gray write pointer is brought
// in through a SYNC_STAGES-deep synchroniser. Empty, almost_empty and the fill
// level are computed from the next-state read pointer and registered, so they
// are always current with the pointer they describe.
//
// Ports:
//   rd_clk        read-domain clock
//   rd_rst        asynchronous active-high reset
//   rd_en         pop request
//   g_wr_ptr      Gray write pointer from the write domain (asynchronous)
//   uf_clr        clears the sticky underflow flag
//   rd_fire       combinational RAM read enable (rd_en && !empty)
//   rd_addr       RAM read address (low AW bits of the binary read pointer)
//   b_rd_ptr      registered binary read pointer
//   g_rd_ptr      registered Gray read pointer, for the write domain
//   empty         registered empty flag
//   almost_empty  registered, level <= AE_LEVEL
//   rd_level      registered occupancy, 0..2**AW
//   underflow     registered sticky underflow flag
module rd_ptr_ctrl #(
  parameter int unsigned AW          = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_LEVEL    = 1
) (
  input  logic          rd_clk,
  input  logic          rd_rst,
  input  logic          rd_en,
  input  logic [AW:0]   g_wr_ptr,
  input  logic          uf_clr,
  output logic          rd_fire,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   b_rd_ptr,
  output logic [AW:0]   g_rd_ptr,
  output logic          empty,
  output logic          almost_empty,
  output logic [AW:0]   rd_level,
  output logic          underflow
);

  localparam int unsigned PW = AW + 1;

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0] g_wr_sync;
  logic [PW-1:0] b_wr_sync;

  logic [PW-1:0] b_rd_ptr_q, b_rd_ptr_d;
  logic [PW-1:0] g_rd_ptr_q, g_rd_ptr_d;
  logic [PW-1:0] rd_level_q, rd_level_d;
  logic          empty_q, empty_d;
  logic          almost_empty_q, almost_empty_d;
  logic          underflow_q, underflow_d;

  // Write-pointer synchroniser; only the last stage is consumed.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= g_wr_ptr;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign g_wr_sync = sync_q[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    b_wr_sync = '0;
    for (int i = 0; i < int'(PW); i++) begin
      b_wr_sync[i] = ^(g_wr_sync >> i);
    end
  end

  // A pop is only honoured while the registered empty flag is low.
  assign rd_fire = rd_en & ~empty_q;

  // Next-state pointers and look-ahead flags derived from them.
  always_comb begin
    b_rd_ptr_d     = b_rd_ptr_q + PW'(rd_fire);
    g_rd_ptr_d     = b_rd_ptr_d ^ (b_rd_ptr_d >> 1);
    rd_level_d     = b_wr_sync - b_rd_ptr_d;
    empty_d        = (g_rd_ptr_d == g_wr_sync);
    almost_empty_d = (rd_level_d <= PW'(AE_LEVEL));
    // Set has priority over clear.
    underflow_d    = (rd_en & empty_q) | (underflow_q & ~uf_clr);
  end

  // Pointer and flag registers.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      b_rd_ptr_q     <= '0;
      g_rd_ptr_q     <= '0;
      rd_level_q     <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
    end else begin
      b_rd_ptr_q     <= b_rd_ptr_d;
      g_rd_ptr_q     <= g_rd_ptr_d;
      rd_level_q     <= rd_level_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      underflow_q    <= underflow_d;
    end
  end

  assign rd_addr      = b_rd_ptr_q[AW-1:0];
  assign b_rd_ptr     = b_rd_ptr_q;
  assign g_rd_ptr     = g_rd_ptr_q;
  assign rd_level     = rd_level_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Directed testbench for rd_ptr_ctrl (AW=3, SYNC_STAGES=2, AE_LEVEL=1).
module tb_rd_ptr_ctrl;

  logic       rd_clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rd_rst = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] g_wr_ptr = 4'd0;
  logic       uf_clr = 1'b0;
  logic       rd_fire;
  logic [2:0] rd_addr;
  logic [3:0] b_rd_ptr;
  logic [3:0] g_rd_ptr;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_level;
  logic       underflow;

  int tests_run = 0;
  int tests_failed = 0;
  logic [3:0] exp_b = 4'd0;
  logic [3:0] prev_g = 4'd0;

  rd_ptr_ctrl #(.AW(3), .SYNC_STAGES(2), .AE_LEVEL(1)) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .rd_en        (rd_en),
    .g_wr_ptr     (g_wr_ptr),
    .uf_clr       (uf_clr),
    .rd_fire      (rd_fire),
    .rd_addr      (rd_addr),
    .b_rd_ptr     (b_rd_ptr),
    .g_rd_ptr     (g_rd_ptr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level),
    .underflow    (underflow)
  );

  always #5 if (clk_run) rd_clk = ~rd_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  // Status vector {b_rd_ptr, rd_level, empty, almost_empty, underflow}.
  function automatic logic [10:0] status();
    return {b_rd_ptr, rd_level, empty, almost_empty, underflow};
  endfunction

  task automatic test_reset();
    #3 rd_rst = 1'b1;
    #1;
    tests_run++;
    if ({status(), g_rd_ptr, rd_addr, rd_fire} !== {4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 1'b0}) begin
      $display("FAIL reset_values: got %h required %h", {status(), g_rd_ptr, rd_addr, rd_fire},
               {4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 1'b0});
      tests_failed++;
    end
  endtask

  task automatic test_sync_latency();
    g_wr_ptr = 4'b0010;
    #2 rd_rst = 1'b0;
    clk_run = 1'b1;
    tick();
    tests_run++;
    if (empty !== 1'b1) begin
      $display("FAIL sync_edge1_empty: got %b required 1", empty);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (empty !== 1'b1) begin
      $display("FAIL sync_edge2_empty: got %b required 1", empty);
      tests_failed++;
    end
    tick();
    tests_run++;
    if ({empty, rd_level, almost_empty} !== {1'b0, 4'd3, 1'b0}) begin
      $display("FAIL sync_edge3: got empty=%b level=%0d ae=%b required empty=0 level=3 ae=0",
               empty, rd_level, almost_empty);
      tests_failed++;
    end
  endtask

  task automatic test_drain();
    logic [10:0] exp_tab [3];
    exp_tab[0] = {4'd1, 4'd2, 1'b0, 1'b0, 1'b0};
    exp_tab[1] = {4'd2, 4'd1, 1'b0, 1'b1, 1'b0};
    exp_tab[2] = {4'd3, 4'd0, 1'b1, 1'b1, 1'b0};
    rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (rd_fire !== 1'b1) begin
        $display("FAIL drain_fire%0d: got %b required 1", k, rd_fire);
        tests_failed++;
      end
      tick();
      tests_run++;
      if (status() !== exp_tab[k]) begin
        $display("FAIL drain_pop%0d: got %h required %h", k, status(), exp_tab[k]);
        tests_failed++;
      end
    end
    tests_run++;
    if (rd_fire !== 1'b0) begin
      $display("FAIL drain_fire_on_empty: got %b required 0", rd_fire);
      tests_failed++;
    end
    tick();
    tests_run++;
    if ({b_rd_ptr, underflow, empty} !== {4'd3, 1'b1, 1'b1}) begin
      $display("FAIL drain_underflow: got ptr=%0d uf=%b empty=%b required ptr=3 uf=1 empty=1",
               b_rd_ptr, underflow, empty);
      tests_failed++;
    end
    rd_en = 1'b0;
  endtask

  task automatic test_uf_clr();
    uf_clr = 1'b1;
    tick();
    tests_run++;
    if (underflow !== 1'b0) begin
      $display("FAIL uf_clear: got %b required 0", underflow);
      tests_failed++;
    end
    rd_en = 1'b1;
    tick();
    tests_run++;
    if (underflow !== 1'b1) begin
      $display("FAIL uf_set_wins: got %b required 1", underflow);
      tests_failed++;
    end
    rd_en = 1'b0;
    uf_clr = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({underflow, b_rd_ptr} !== {1'b1, 4'd3}) begin
      $display("FAIL uf_sticky: got uf=%b ptr=%0d required uf=1 ptr=3", underflow, b_rd_ptr);
      tests_failed++;
    end
    uf_clr = 1'b1;
    tick();
    uf_clr = 1'b0;
    tests_run++;
    if (underflow !== 1'b0) begin
      $display("FAIL uf_clear2: got %b required 0", underflow);
      tests_failed++;
    end
  endtask

  // Move the write pointer to w, wait out the synchroniser, then pop n words.
  task automatic write_and_pop(input logic [3:0] w, input int n, input string tag);
    logic [3:0] lvl;
    g_wr_ptr = gray(w);
    tick(); tick(); tick();
    lvl = w - exp_b;
    tests_run++;
    if ({rd_level, empty} !== {lvl, 1'b0}) begin
      $display("FAIL %s_level_start: got level=%0d empty=%b required level=%0d empty=0",
               tag, rd_level, empty, lvl);
      tests_failed++;
    end
    rd_en = 1'b1;
    for (int k = 1; k <= n; k++) begin
      prev_g = g_rd_ptr;
      tick();
      exp_b = exp_b + 4'd1;
      lvl = w - exp_b;
      tests_run++;
      if ({b_rd_ptr, rd_addr, g_rd_ptr, rd_level, empty, almost_empty} !==
          {exp_b, exp_b[2:0], gray(exp_b), lvl, lvl == 4'd0, lvl <= 4'd1}) begin
        $display("FAIL %s_pop%0d: got b=%0d a=%0d g=%b lvl=%0d e=%b ae=%b required b=%0d g=%b lvl=%0d",
                 tag, k, b_rd_ptr, rd_addr, g_rd_ptr, rd_level, empty, almost_empty,
                 exp_b, gray(exp_b), lvl);
        tests_failed++;
      end
      tests_run++;
      if ($countones(g_rd_ptr ^ prev_g) != 1) begin
        $display("FAIL %s_gray_step%0d: got %b from %b required one bit change", tag, k, g_rd_ptr, prev_g);
        tests_failed++;
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_wrap();
    exp_b = 4'd3;
    write_and_pop(4'd8, 5, "preload_a");
    write_and_pop(4'd14, 6, "preload_b");
    write_and_pop(4'd4, 6, "wrap");
    tests_run++;
    if ({b_rd_ptr, empty, underflow} !== {4'd4, 1'b1, 1'b0}) begin
      $display("FAIL wrap_end: got b=%0d e=%b uf=%b required b=4 e=1 uf=0", b_rd_ptr, empty, underflow);
      tests_failed++;
    end
  endtask

  task automatic test_full_and_reset();
    g_wr_ptr = gray(4'd12);
    tick(); tick(); tick();
    tests_run++;
    if ({rd_level, empty, almost_empty} !== {4'd8, 1'b0, 1'b0}) begin
      $display("FAIL full_level: got lvl=%0d e=%b ae=%b required lvl=8 e=0 ae=0",
               rd_level, empty, almost_empty);
      tests_failed++;
    end
    rd_en = 1'b1;
    tick();
    tests_run++;
    if ({b_rd_ptr, rd_level} !== {4'd5, 4'd7}) begin
      $display("FAIL full_pop: got b=%0d lvl=%0d required b=5 lvl=7", b_rd_ptr, rd_level);
      tests_failed++;
    end
    #2 rd_rst = 1'b1;
    #1;
    tests_run++;
    if ({status(), g_rd_ptr, rd_fire} !== {4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0}) begin
      $display("FAIL midop_reset: got %h required %h", {status(), g_rd_ptr, rd_fire},
               {4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0});
      tests_failed++;
    end
    rd_en = 1'b0;
    g_wr_ptr = gray(4'd5);
    #2 rd_rst = 1'b0;
    tick();
    tests_run++;
    if ({empty, b_rd_ptr} !== {1'b1, 4'd0}) begin
      $display("FAIL post_reset_edge1: got e=%b b=%0d required e=1 b=0", empty, b_rd_ptr);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (empty !== 1'b1) begin
      $display("FAIL post_reset_edge2: got e=%b required 1", empty);
      tests_failed++;
    end
    tick();
    tests_run++;
    if ({empty, rd_level, almost_empty} !== {1'b0, 4'd5, 1'b0}) begin
      $display("FAIL post_reset_edge3: got e=%b lvl=%0d ae=%b required e=0 lvl=5 ae=0",
               empty, rd_level, almost_empty);
      tests_failed++;
    end
  endtask

  initial begin
    test_reset();
    test_sync_latency();
    test_drain();
    test_uf_clr();
    test_wrap();
    test_full_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rd_ptr_ctrl.md
Name: rd_ptr_ctrl

Overview:
- Parametrised read-side pointer controller for the asynchronous FIFO; successor to the fixed-width read pointer handler.
- Runs entirely in the read clock domain. Synchronises the Gray write pointer internally over SYNC_STAGES flops.
- Maintains binary and Gray read pointers and drives the RAM read address/enable.
- Produces look-ahead registered empty, almost_empty, a fill level, and a sticky underflow flag.

Parameters:
- AW, 3: address width; FIFO depth = 2**AW; pointers are AW+1 bits.
- SYNC_STAGES, 2: flops in the g_wr_ptr synchroniser; legal range 2..4.
- AE_LEVEL, 1: almost_empty asserts when level <= AE_LEVEL; legal range 0..2**AW-1.

Ports:
- rd_clk  in  1  read-domain clock; all flops rise on posedge.
- rd_rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  pop request.
- g_wr_ptr  in  AW+1  Gray write pointer, launched from the write domain (asynchronous to rd_clk).
- uf_clr  in  1  clears the underflow flag.
- rd_fire  out  1  combinational rd_en && !empty; RAM read enable.
- rd_addr  out  AW  b_rd_ptr[AW-1:0].
- b_rd_ptr  out  AW+1  binary read pointer (registered).
- g_rd_ptr  out  AW+1  Gray read pointer (registered), for the write domain.
- empty  out  1  registered.
- almost_empty  out  1  registered.
- rd_level  out  AW+1  registered occupancy, 0..2**AW.
- underflow  out  1  registered, sticky.

Behaviour:
- Reset (async assert, sync release): b_rd_ptr=0, g_rd_ptr=0, all sync flops=0, empty=1, almost_empty=1, rd_level=0, underflow=0. Reset applied mid-operation discards the pointer state immediately; no partial pop completes.
- Synchroniser: g_wr_ptr is shifted through SYNC_STAGES flops. Only the last stage (g_wr_sync) is used. No other logic touches g_wr_ptr.
- Next pointer: b_next = b_rd_ptr + rd_fire, modulo 2**(AW+1), with natural wrap. g_next = b_next ^ (b_next >> 1). Both pointers register b_next/g_next every cycle. Gray output is registered, so only one bit changes per pop.
- Write pointer to binary: b_wr_sync[AW] = g_wr_sync[AW]; b_wr_sync[i] = b_wr_sync[i+1] ^ g_wr_sync[i]. This is combinational.
- Look-ahead flags are registered each edge from the next-state values:
  - empty <= (g_next == g_wr_sync).
  - level_next = (b_wr_sync - b_next) modulo 2**(AW+1); rd_level <= level_next.
  - almost_empty <= (level_next <= AE_LEVEL).
- Consequence: a pop of the last word raises empty on the same edge that advances the pointer, so no zero-cycle window exists in which empty is low on an empty FIFO.
- Latency: a g_wr_ptr change stable before edge 1 reaches g_wr_sync after SYNC_STAGES edges. empty, rd_level and almost_empty reflect it on edge SYNC_STAGES+1.
- Pop rule: a pop occurs only when rd_en=1 and empty=0. rd_en with empty=1 leaves the pointers unchanged.
- Underflow:
  - Set on any edge where rd_en=1 and empty=1.
  - Cleared by uf_clr=1.
  - If set and clear coincide, set wins.
  - Held until cleared or reset.
- Wrap-around: the pointer rolls from 2**(AW+1)-1 to 0. The Gray MSB toggles at AW-bit boundaries so the write side can detect full. Level arithmetic stays correct across the wrap.
- Full FIFO: rd_level = 2**AW is legal. The read side never flags full.
- g_wr_sync ahead of the read pointer by more than 2**AW is illegal upstream. The behaviour in that case is undefined, and the bench must never drive it.
- No combinational path from g_wr_ptr to any output. rd_fire depends only on rd_en and the empty register.

Test Plan (AW=3, SYNC_STAGES=2, AE_LEVEL=1):
- Reset check: assert rd_rst mid-clock with rd_clk stopped -> outputs go to reset values immediately (empty=1, almost_empty=1, pointers 0, rd_level=0, underflow=0).
- Sync latency: from reset, drive g_wr_ptr=Gray(3)=4'b0010 before edge 1 -> empty=1 through edge 2; edge 3: empty=0, rd_level=3, almost_empty=0.
- Drain to empty: with write pointer at 3, hold rd_en for 3 cycles:
  - rd_fire=1 on each cycle; b_rd_ptr steps 1,2,3.
  - almost_empty=1 when rd_level=1.
  - empty=1 on the same edge that b_rd_ptr becomes 3.
  - A 4th rd_en gives rd_fire=0, pointer held at 3, underflow=1.
- Underflow clear: underflow=1, assert uf_clr with rd_en=0 -> underflow=0 next edge. Assert uf_clr together with rd_en on empty -> underflow stays 1.
- Wrap: preload by writing and reading 14 words, then write pointer Gray(20 mod 16)=Gray(4), 6 more pops -> b_rd_ptr passes 15->0; g_rd_ptr changes one bit per pop; rd_level counts 6..0 correctly; empty=1 at b_rd_ptr=4.
- Full level and mid-op reset: write pointer 8 ahead -> rd_level=8. Assert rd_rst while rd_en=1 -> pointers 0 immediately; after release, empty tracks the synchronised g_wr_ptr after 3 edges.
